// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
//   Sends one command byte from the host to a PS/2 mouse: 0xF4 (enable data
//   reporting) or 0xF5 (disable). It runs request-to-send, the 8 data bits LSB
//   first, odd parity, stop and the device acknowledge, then pulses done or
//   error.
//
// Ports
//   iClk               system clock
//   iResetn            asynchronous active-low reset
//   iStartTransmission start request, sampled only while idle
//   iEnableMouse       1 = send CMD_ENABLE, 0 = send CMD_DISABLE (latched with start)
//   iPS2Clk, iPS2Dat   raw PS/2 pins (asynchronous)
//   oPS2ClkLow         1 = pull PS/2 clock low, 0 = release
//   oPS2DatLow         1 = pull PS/2 data low, 0 = release
//   oBusy              high whenever a transfer is in progress
//   oDone              one-cycle pulse: ACK received and bus back to idle
//   oError             one-cycle pulse: NACK or timeout
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter logic [7:0]  CMD_ENABLE     = 8'hF4,
  parameter logic [7:0]  CMD_DISABLE    = 8'hF5
) (
  input  logic iClk,
  input  logic iResetn,
  input  logic iStartTransmission,
  input  logic iEnableMouse,
  input  logic iPS2Clk,
  input  logic iPS2Dat,
  output logic oPS2ClkLow,
  output logic oPS2DatLow,
  output logic oBusy,
  output logic oDone,
  output logic oError
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_IDLE, S_ERR
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers; idle-high so reset never fakes a falling edge
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev;
  logic       clk_s, dat_s, clk_fall;

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], iPS2Clk};
      dat_sync <= {dat_sync[0], iPS2Dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s    = clk_sync[1];
  assign dat_s    = dat_sync[1];
  assign clk_fall = clk_prev & ~clk_s;

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       bit_q, bit_d;     // falling edges seen in SEND
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             clk_low_d, dat_low_d, busy_d, done_d, err_d;
  logic [7:0]       cmd;
  logic [2:0]       bit_sel;

  assign cmd = iEnableMouse ? CMD_ENABLE : CMD_DISABLE;

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state_q    <= S_IDLE;
      inh_q      <= '0;
      tmo_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      oPS2ClkLow <= 1'b0;
      oPS2DatLow <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oError     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_q      <= inh_d;
      tmo_q      <= tmo_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      oPS2ClkLow <= clk_low_d;
      oPS2DatLow <= dat_low_d;
      oBusy      <= busy_d;
      oDone      <= done_d;
      oError     <= err_d;
    end
  end

  // Next state; the pin outputs are then decoded from the *next* state so the
  // registered outputs line up with the state they belong to, glitch-free.
  always_comb begin
    state_d = state_q;
    inh_d   = inh_q;
    tmo_d   = tmo_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStartTransmission) begin
          shift_d = cmd;
          par_d   = ~^cmd;           // odd parity
          inh_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          tmo_d   = '0;
          bit_d   = '0;
          state_d = S_RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_RTS: begin
        tmo_d   = tmo_q + 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        tmo_d = tmo_q + 1'b1;
        if (clk_fall) begin
          bit_d = bit_q + 4'd1;
          // 11th edge: device drives its acknowledge on the data line
          if (bit_q == 4'd10)
            state_d = dat_s ? S_ERR : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        tmo_d = tmo_q + 1'b1;
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Timeout overrides bit position, but a completed handshake wins a tie.
    if ((state_q == S_RTS || state_q == S_SEND || state_q == S_WAIT_IDLE) &&
        tmo_q == TMO_LAST && !done_d)
      state_d = S_ERR;
  end

  // Edges 1..8 map to D0..D7; low three bits minus one wraps 8 onto index 7.
  assign bit_sel = bit_d[2:0] - 3'd1;

  always_comb begin
    clk_low_d = (state_d == S_INHIBIT);
    busy_d    = (state_d != S_IDLE);
    err_d     = (state_d == S_ERR);
    dat_low_d = 1'b0;
    case (state_d)
      S_INHIBIT: dat_low_d = (inh_d == INH_LAST);   // start bit in last cycle
      S_RTS:     dat_low_d = 1'b1;
      S_SEND: begin
        if (bit_d == 4'd0)      dat_low_d = 1'b1;   // start bit still held
        else if (bit_d <= 4'd8) dat_low_d = ~shift_d[bit_sel];
        else if (bit_d == 4'd9) dat_low_d = ~par_d;
        else                    dat_low_d = 1'b0;   // stop bit / ACK window
      end
      default:   dat_low_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Testbench for ps2_host_transmitter: a mouse model clocks the open-drain bus,
// captures the bits the host presents and answers ACK/NACK; results are
// compared against a byte/parity model derived from the command rules.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;
  localparam int INH = 10;
  localparam int TMO = 200;

  logic iClk = 1'b0, iResetn = 1'b0, start = 1'b0, en = 1'b0;
  logic mclk = 1'b1, mdat = 1'b1;
  logic ps2_clk, ps2_dat;
  logic oPS2ClkLow, oPS2DatLow, oBusy, oDone, oError;

  // open-drain wired-AND of host and mouse
  assign ps2_clk = oPS2ClkLow ? 1'b0 : mclk;
  assign ps2_dat = oPS2DatLow ? 1'b0 : mdat;

  always #5 iClk = ~iClk;

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .iClk(iClk), .iResetn(iResetn), .iStartTransmission(start),
    .iEnableMouse(en), .iPS2Clk(ps2_clk), .iPS2Dat(ps2_dat),
    .oPS2ClkLow(oPS2ClkLow), .oPS2DatLow(oPS2DatLow), .oBusy(oBusy),
    .oDone(oDone), .oError(oError));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int run = 0, last_run = 0, rts_cyc = 0, err_cyc = 0, inh_starts = 0;
  logic clk_low_d1 = 1'b0;

  // bus monitor: pulse counts, clock-low run length, RTS and error timestamps
  always @(negedge iClk) begin
    cyc <= cyc + 1;
    if (oDone) done_cnt <= done_cnt + 1;
    if (oError) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
    if (oDone && oError) both_cnt <= both_cnt + 1;
    if (oPS2ClkLow) begin
      run <= run + 1;
      if (!clk_low_d1) inh_starts <= inh_starts + 1;
    end else if (run != 0) begin
      last_run <= run;
      run      <= 0;
      rts_cyc  <= cyc;
    end
    clk_low_d1 <= oPS2ClkLow;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // Expected pin bits: [7:0] data LSB first, [8] odd parity, [9] stop.
  function automatic logic [9:0] exp_bits(input bit e);
    logic [7:0] b;
    logic       p;
    b = e ? 8'hF4 : 8'hF5;
    p = (($countones(b) % 2) == 0);
    return {1'b1, p, b};
  endfunction

  // Mouse model: nedge falling edges, sampling the line just before each
  // rising edge; on edge 11 it drives ACK (0) or leaves data high (NACK).
  task automatic mouse(input int nedge, input int half, input bit ack,
                       input int poke_edge, input int rst_edge,
                       output logic [9:0] bits);
    bits = '0;
    for (int k = 1; k <= nedge; k++) begin
      if (k == 11) begin
        tick(half - 2);
        mdat = ack ? 1'b0 : 1'b1;
        tick(2);
      end else begin
        tick(half);
      end
      mclk = 1'b0;
      if (k == rst_edge) begin
        tick(3);
        #2 iResetn = 1'b0;
        #1;
        check("rst_mid clklow", 32'(oPS2ClkLow), 0);
        check("rst_mid datlow", 32'(oPS2DatLow), 0);
        check("rst_mid busy",   32'(oBusy), 0);
        mclk = 1'b1;
        mdat = 1'b1;
        return;
      end
      if (k == poke_edge) begin
        start = 1'b1;
        en    = ~en;
        tick(1);
        start = 1'b0;
        tick(half - 1);
      end else begin
        tick(half);
      end
      if (k <= 10) bits[k-1] = ps2_dat;
      mclk = 1'b1;
    end
    tick(2);
    mdat = 1'b1;
  endtask

  task automatic run_frame(input bit e, input int half, input bit ack, input int nedge,
                           input int poke_edge, input int rst_edge, input string tag);
    logic [9:0] bits, expv, mask;
    int d0, e0, i0, k;
    bit exp_done;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_starts;
    en = e; start = 1'b1;
    tick(1);
    start = 1'b0;
    en = 1'($urandom_range(0, 1));   // must not matter after the start
    check({tag, " inhibit_on"}, 32'(oPS2ClkLow), 1);
    k = 0;
    while (oPS2ClkLow && k < INH + 5) begin tick(1); k++; end
    tick(1);
    check({tag, " inhibit_len"}, 32'(last_run), INH);
    check({tag, " start_bit"},   32'(ps2_dat), 0);
    check({tag, " busy_frame"},  32'(oBusy), 1);
    mouse(nedge, half, ack, poke_edge, rst_edge, bits);

    if (rst_edge != 0) begin
      tick(5);
      iResetn = 1'b1;
      tick(300);
      check({tag, " done_none"}, 32'(done_cnt - d0), 0);
      check({tag, " err_none"},  32'(err_cnt - e0), 0);
      check({tag, " busy_idle"}, 32'(oBusy), 0);
      check({tag, " inh_once"},  32'(inh_starts - i0), 1);
      return;
    end

    expv = exp_bits(e);
    mask = (nedge >= 10) ? 10'h3FF : 10'((1 << nedge) - 1);
    check({tag, " bits"}, 32'(bits & mask), 32'(expv & mask));

    k = 0;
    while (done_cnt == d0 && err_cnt == e0 && k < TMO + 50) begin tick(1); k++; end
    tick(20);
    exp_done = (nedge == 11) && ack;
    check({tag, " done_cnt"},  32'(done_cnt - d0), exp_done ? 1 : 0);
    check({tag, " err_cnt"},   32'(err_cnt - e0), exp_done ? 0 : 1);
    check({tag, " one_frame"}, 32'(inh_starts - i0), 1);
    check({tag, " busy_idle"}, 32'(oBusy), 0);
    check({tag, " released"},  32'({oPS2ClkLow, oPS2DatLow}), 0);
    check({tag, " no_overlap"}, 32'(both_cnt), 0);
    if (nedge < 11)
      check({tag, " timeout_at"}, 32'(err_cyc - rts_cyc), TMO);
  endtask

  initial begin
    tick(3);
    check("reset clklow", 32'(oPS2ClkLow), 0);
    check("reset datlow", 32'(oPS2DatLow), 0);
    check("reset busy",   32'(oBusy), 0);
    check("reset done",   32'(oDone), 0);
    check("reset error",  32'(oError), 0);
    iResetn = 1'b1;
    tick(3);

    run_frame(1'b1, 6, 1'b1, 11, 0, 0, "enable");
    run_frame(1'b0, 6, 1'b1, 11, 0, 0, "disable");
    run_frame(1'b1, 6, 1'b0, 11, 0, 0, "nack");
    run_frame(1'b0, 6, 1'b1, 4,  0, 0, "timeout");
    run_frame(1'b1, 6, 1'b1, 11, 5, 0, "busy_ignore");
    run_frame(1'b1, 6, 1'b1, 11, 0, 6, "reset_mid");
    for (int r = 0; r < 6; r++)
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(5, 7)),
                ($urandom_range(0, 3) != 0), 11, 0, 0, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
- Host-to-mouse PS/2 transmitter; the responder to the drawing control path's oStartTransmission/oEnableMouse request.
- On a start pulse it sends one command byte to the mouse over the open-drain PS/2 clock/data pair:
  - 0xF4 (enable data reporting) when iEnableMouse=1.
  - 0xF5 (disable) when iEnableMouse=0.
- Runs the full request-to-send, bit-shift, parity, stop and acknowledge sequence, then reports done or error.
- Sits beside the PS/2 receiver in the mouse interface; its outputs drive the top-level tri-state buffers.

Parameters:
- INHIBIT_CYCLES, 5000: iClk cycles the PS/2 clock is held low for request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: iClk cycles allowed from clock release to ACK received (15 ms at 50 MHz).
- CMD_ENABLE, 8'hF4: byte sent when iEnableMouse=1.
- CMD_DISABLE, 8'hF5: byte sent when iEnableMouse=0.

Ports:
- iClk  in  1  source clock.
- iResetn  in  1  asynchronous active-low reset.
- iStartTransmission  in  1  level/pulse; sampled only in IDLE.
- iEnableMouse  in  1  selects the command byte; latched together with the start.
- iPS2Clk  in  1  raw PS/2 clock pin (asynchronous).
- iPS2Dat  in  1  raw PS/2 data pin (asynchronous).
- oPS2ClkLow  out  1  1 = drive clock pin low; 0 = release (high-Z).
- oPS2DatLow  out  1  1 = drive data pin low; 0 = release (high-Z).
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse on ACK=0 received and bus idle.
- oError  out  1  one-cycle pulse on NACK or timeout.

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE.
  - All outputs are 0; both lines are released immediately.
  - Synchronizer flops are set to 1; counters are cleared.
- Input conditioning:
  - iPS2Clk and iPS2Dat each pass through a 2-flop synchronizer.
  - A falling edge is synchronized clock 1 in the previous cycle and 0 in the current cycle.
- IDLE:
  - When iStartTransmission=1, the command byte (selected by iEnableMouse) is latched into the shift register.
  - Odd parity is computed: parity = ~^byte. F4 gives parity 0; F5 gives parity 1.
  - Next state is INHIBIT.
  - oPS2ClkLow rises on the cycle after start is sampled.
- INHIBIT:
  - oPS2ClkLow=1 for exactly INHIBIT_CYCLES cycles.
  - In the final cycle oPS2DatLow is set to 1 (start bit).
  - Next state is RTS.
- RTS: oPS2ClkLow=0, oPS2DatLow=1. Timeout counter cleared and started. Next state is SEND.
- SEND: the bit counter advances on each synchronized clock falling edge.
  - Edges 1–8: present data bits D0..D7, LSB first (oPS2DatLow = ~bit).
  - Edge 9: present the parity bit.
  - Edge 10: present the stop bit (oPS2DatLow=0).
  - Edge 11: sample the synchronized data. 0 means ACK and the next state is WAIT_IDLE; 1 means NACK and the next state is ERR.
- WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse oDone for one cycle and return to IDLE.
- ERR: pulse oError for one cycle, force both lines released, return to IDLE.
- Timeout:
  - Counts in RTS, SEND and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES-1 without completion, go to ERR regardless of the bit position.
- Simultaneous events and line handling:
  - Start asserted while busy is ignored; no queuing.
  - oDone and oError are never high together.
  - oPS2ClkLow is never 1 outside INHIBIT.
- Reset mid-frame: lines are released the same instant; no done or error pulse is generated.
- Unused state encodings go to IDLE with lines released.

Test Plan:
- Enable command (INHIBIT_CYCLES=10 for sim):
  - Stimulus: start=1 with iEnableMouse=1; the bench mouse model generates 11 falling clock edges and drives ACK=0 on edge 11.
  - Required: oPS2ClkLow high for 10 cycles; bits seen on the pin at falling edges are 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Required: oDone pulses for one cycle and oBusy drops.
- Disable command: iEnableMouse=0 → pin bits 1,0,1,0,1,1,1,1, parity 1, stop 1; oDone pulses.
- NACK: mouse model holds data high on edge 11 → oError pulses for 1 cycle, oDone stays 0, both lines released, state IDLE.
- Timeout (TIMEOUT_CYCLES=200): mouse model stops clocking after edge 4 → oError is pulsed at the 200th cycle after RTS, and lines are released.
- Busy ignore: second start pulse at edge 5 → exactly one frame is transmitted and one oDone is seen.
- Reset mid-frame: iResetn=0 during edge 6 → oPS2ClkLow=oPS2DatLow=0 asynchronously, oBusy=0, and no oDone or oError after reset is released.
